// File: rtl/memory_cycle_if.sv
// Data-memory bus between the M stage (master) and the memory (slave).
// Request/grant phase for address and write data, then rvalid for load data.
interface memory_cycle_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/memory_cycle.sv
// RISC-V M stage: word load/store over req/gnt/rvalid, M/W register, stall and watchdog abort.
// Define MEM_MISALIGN_CHK_EN to suppress accesses whose address is not word aligned.
module memory_cycle #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    AluResult_M,
  input  logic [31:0]    WriteData_M,
  input  logic [4:0]     Rd_M,
  input  logic           RegWrite_M,
  input  logic           ResultSrc_M,
  input  logic           MemWrite_M,
  output logic           stall_M,
  memory_cycle_if.master dmem,
  output logic [31:0]    AluResult_W,
  output logic [31:0]    ReadData_W,
  output logic [4:0]     Rd_W,
  output logic           RegWrite_W,
  output logic           ResultSrc_W,
  output logic           bus_err_W,
  output logic           misalign_W
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] alu_q, alu_d;
  logic [31:0] rdata_q, rdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic        rs_q, rs_d;
  logic        buserr_q, buserr_d;
  logic        mis_q, mis_d;

  logic access;
  logic misalign;
  logic at_limit;
  logic req;
  logic mem_done;
  logic load_done;
  logic timeout;
  logic done;

  // Both ResultSrc_M and MemWrite_M set is treated as a store.
  assign access   = ResultSrc_M | MemWrite_M;
  assign at_limit = (cnt_q == CNT_W'(MAX_WAIT - 1));

`ifdef MEM_MISALIGN_CHK_EN
  assign misalign = access && (state_q == StIdle) && (AluResult_M[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req       = 1'b0;
    mem_done  = 1'b0;
    load_done = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      StIdle: begin
        // At the limit the request is withdrawn, so a late grant cannot be taken.
        if (access && !misalign) begin
          if (at_limit) begin
            timeout = 1'b1;
          end else begin
            req = 1'b1;
            if (dmem.gnt) begin
              if (MemWrite_M) mem_done = 1'b1;
              else            state_d  = StWait;
            end
          end
        end
      end
      StWait: begin
        if (dmem.rvalid) begin
          mem_done  = 1'b1;
          load_done = 1'b1;
          state_d   = StIdle;
        end else if (at_limit) begin
          timeout = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    done = mem_done | timeout | misalign;
    if (done || (state_q == StIdle && !access)) cnt_d = '0;
    else                                       cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    alu_d    = alu_q;
    rdata_d  = rdata_q;
    rd_d     = rd_q;
    rw_d     = 1'b0;
    rs_d     = 1'b0;
    buserr_d = 1'b0;
    mis_d    = 1'b0;
    if (timeout) begin
      buserr_d = 1'b1;
    end else if (misalign) begin
      mis_d = 1'b1;
    end else if (!access || mem_done) begin
      alu_d = AluResult_M;
      rd_d  = Rd_M;
      rw_d  = RegWrite_M;
      rs_d  = ResultSrc_M;
      if (load_done) rdata_d = dmem.rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      alu_q    <= '0;
      rdata_q  <= '0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      rs_q     <= 1'b0;
      buserr_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alu_q    <= alu_d;
      rdata_q  <= rdata_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      rs_q     <= rs_d;
      buserr_q <= buserr_d;
      mis_q    <= mis_d;
    end
  end

  // Reset masks the combinational outputs immediately, not at the next edge.
  assign stall_M    = access & ~done & rst;
  assign dmem.req   = req & rst;
  assign dmem.we    = MemWrite_M;
  assign dmem.addr  = AluResult_M;
  assign dmem.wdata = WriteData_M;

  assign AluResult_W = alu_q;
  assign ReadData_W  = rdata_q;
  assign Rd_W        = rd_q;
  assign RegWrite_W  = rw_q;
  assign ResultSrc_W = rs_q;
  assign bus_err_W   = buserr_q;
  assign misalign_W  = mis_q;

endmodule
